fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 13 +
 rtl/memoria_dp.sv | 31 +++
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller and its storage.
package fifo_pkg;

  localparam int DATA_W_DEF    = 12;
  localparam int ADDR_W_DEF    = 3;
  localparam int AF_THRESH_DEF = 6;
  localparam int AE_THRESH_DEF = 2;

  function automatic bit thresh_legal(input int ae, input int af, input int depth);
    return (ae > 0) && (ae < af) && (af < depth);
  endfunction

endpackage

// File: rtl/memoria_dp.sv
// Simple dual-port storage: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module memoria_dp #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_e,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [DATA_W-1:0] data_w,
  input  logic              rd_e,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic [DATA_W-1:0] data_r
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_e) mem[wr_ptr] <= data_w;
  end

  // Same-address write and read on one edge returns the old word (full + push/pop).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  data_r <= '0;
    else if (rd_e) data_r <= mem[rd_ptr];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status flags and sticky errors.
// Storage lives in memoria_dp; data_out is its registered read port.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_e,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_e,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  generate
    if (!thresh_legal(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
      $error("fifo_ctrl: need 0 < AE_THRESH < AF_THRESH < DEPTH");
    end
  endgenerate

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign pop_ok  = rd_e && !empty;
  assign push_ok = wr_e && (!full || rd_e);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_e && full && !rd_e) overflow_err  <= 1'b1;
      if (rd_e && empty)         underflow_err <= 1'b1;
    end
  end

  memoria_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_e    (push_ok),
    .wr_ptr  (wr_ptr),
    .data_w  (data_in),
    .rd_e    (pop_ok),
    .rd_ptr  (rd_ptr),
    .data_r  (data_out)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: queue-based reference model, monitor checks popped data.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        wr_e = 1'b0;
  logic        rd_e = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out;
  logic        valid_out, full, empty, almost_full, almost_empty;
  logic [3:0]  count;
  logic        overflow_err, underflow_err;

  fifo_ctrl dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .wr_e          (wr_e),
    .data_in       (data_in),
    .rd_e          (rd_e),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] model_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] last_exp = '0;
  bit          m_ovf = 0, m_unf = 0;
  bit          mon_en = 0;
  int          valid_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid_out must match the oldest expected pop; otherwise data_out holds.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out === 1'b1) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          last_exp = exp_q.pop_front();
          chk("data_out", data_out, last_exp);
        end
      end else begin
        chk("data_hold", data_out, last_exp);
      end
    end
  end

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count", count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= AF);
    chk("almost_empty", almost_empty, n <= AE);
    chk("overflow_err", overflow_err, m_ovf);
    chk("underflow_err", underflow_err, m_unf);
    chk("sb_pending", exp_q.size(), 0);
  endtask

  task automatic cycle(input bit w, input logic [11:0] d, input bit r);
    bit pop_ok, push_ok;
    wr_e = w; data_in = d; rd_e = r;
    pop_ok  = r && model_q.size() > 0;
    push_ok = w && (model_q.size() < DEPTH || r);
    if (w && model_q.size() == DEPTH && !r) m_ovf = 1;
    if (r && model_q.size() == 0) m_unf = 1;
    if (pop_ok)  exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    #1;
    wr_e = 0; rd_e = 0;
    check_state();
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    m_ovf = 0; m_unf = 0; last_exp = '0;
    check_state();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    wr_e = 1; rd_e = 1; data_in = 12'h5A5;
    @(posedge clk);
    @(negedge clk);
    #1;
    wr_e = 0; rd_e = 0;
    reset_L = 1'b1;
    check_state();
  endtask

  initial begin
    logic [11:0] d;
    #2;
    do_reset();
    mon_en = 1;

    // Three pushes, three pops
    valid_cnt = 0;
    cycle(1, 12'h00A, 0);
    cycle(1, 12'h0AA, 0);
    cycle(1, 12'h0BB, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1);
    cycle(0, '0, 0);
    chk("valid_cycles", valid_cnt, 3);

    // Fill to full, then a dropped push
    for (int i = 1; i <= 8; i++) cycle(1, 12'(i), 0);
    cycle(1, 12'h777, 0);

    // Full with push+pop, then drain
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, 12'(i), 0);
    cycle(1, 12'h0FF, 1);
    for (int i = 0; i < 8; i++) cycle(0, '0, 1);

    // Empty with push+pop: pop rejected, no bypass
    cycle(1, 12'h0C3, 1);
    cycle(0, '0, 1);

    // Wrap: prefill 3, 20 simultaneous push/pop, drain
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 12'(12'h100 + i), 0);
    for (int i = 0; i < 20; i++) begin
      d = 12'($urandom);
      cycle(1, d, 1);
    end
    for (int i = 0; i < 3; i++) cycle(0, '0, 1);

    // Asynchronous reset mid-stream with 5 stored words
    for (int i = 0; i < 5; i++) cycle(1, 12'(12'h200 + i), 0);
    cycle(0, '0, 1);
    #3;
    do_reset();
    cycle(0, '0, 1);

    // Randomized traffic at varying push/pop densities
    do_reset();
    for (int blk = 0; blk < 4; blk++) begin
      int pw, pr;
      pw = (blk == 0) ? 80 : (blk == 1) ? 30 : 55;
      pr = (blk == 0) ? 30 : (blk == 1) ? 80 : 55;
      for (int i = 0; i < 100; i++) begin
        d = 12'($urandom);
        cycle($urandom_range(0, 99) < pw, d, $urandom_range(0, 99) < pr);
      end
    end
    while (model_q.size() > 0) cycle(0, '0, 1);
    cycle(0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
